// File: rtl/shift_add_mac.sv
// shift_add_mac: sequential shift-and-add multiply-accumulate driving an external barrel shifter
module shift_add_mac (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clear,
  input  logic [7:0]  a,
  input  logic [15:0] b,
  input  logic [33:0] sh_out,
  output logic [7:0]  sh_in,
  output logic [4:0]  sh_n,
  output logic        busy,
  output logic        done,
  output logic [33:0] acc,
  output logic        overflow
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [7:0] a_reg;
  logic [15:0] b_reg;
  logic [3:0] cnt;
  logic [34:0] sum;
  assign sum = {1'b0, acc} + {1'b0, sh_out};
  // status flags decode the state register; shifter is only driven while walking bits
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    sh_in = state == RUN ? a_reg : '0;
    sh_n = state == RUN ? {1'b0, cnt} : '0;
  end
  // accept in IDLE or on the DONE exit edge for back-to-back throughput; walk one multiplier bit per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      cnt <= '0;
      acc <= '0;
      overflow <= 1'b0;
    end else if (state != RUN) begin
      if (start) begin
        a_reg <= a;
        b_reg <= b;
        cnt <= '0;
        state <= RUN;
        if (clear) begin
          acc <= '0;
          overflow <= 1'b0;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end else begin
      if (b_reg[cnt]) begin
        acc <= sum[33:0];
        overflow <= overflow | sum[34];
      end
      cnt <= cnt + 4'd1;
      if (cnt == 4'd15) state <= DONE;
    end
  end
endmodule
